// File: rtl/wave_playback_ctrl.sv
// wave_playback_ctrl: loops sample playback over a UI-selected window, one-entry prefetch
// over a req/ack memory port, one sample delivered per audio tick.
module wave_playback_ctrl #(
   parameter int WW_WIDTH = 18,
   parameter int WS_WIDTH = 30
) (
   input  logic                clk_in,
   input  logic                rst_in,
   input  logic [WS_WIDTH-1:0] wave_start_in,
   input  logic [WW_WIDTH-1:0] wave_width_in,
   input  logic                update_trig_in,
   input  logic                sample_tick_in,
   output logic                mem_req_out,
   output logic [WS_WIDTH-1:0] mem_addr_out,
   input  logic                mem_ack_in,
   input  logic [15:0]         mem_data_in,
   output logic [15:0]         sample_out,
   output logic                sample_valid_out,
   output logic                underrun_out,
   output logic                playing_out
);
   typedef enum logic [1:0] {IDLE, FETCH, FULL, DRAIN} state_t;
   state_t              state_q;
   logic [WS_WIDTH-1:0] start_q, addr_q, addr_d;
   logic [WW_WIDTH-1:0] width_q, idx_q, idx_d;
   logic [15:0]         buf_q, sample_q;
   logic                req_q, valid_q, underrun_q, playing_q, ack;
   assign ack    = mem_ack_in & req_q;
   assign idx_d  = (idx_q == width_q - 1'b1) ? '0 : idx_q + 1'b1;
   assign addr_d = start_q + WS_WIDTH'(idx_q);
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= IDLE;
         start_q    <= '0;
         width_q    <= '0;
         idx_q      <= '0;
         addr_q     <= '0;
         buf_q      <= '0;
         sample_q   <= '0;
         req_q      <= 1'b0;
         valid_q    <= 1'b0;
         underrun_q <= 1'b0;
         playing_q  <= 1'b0;
      end else begin
         valid_q    <= sample_tick_in;
         underrun_q <= 1'b0;
         if (update_trig_in) begin
            start_q <= wave_start_in;
            width_q <= wave_width_in;
            idx_q   <= '0;
            if (wave_width_in == '0) begin
               state_q   <= IDLE;
               playing_q <= 1'b0;
               req_q     <= 1'b0;
               sample_q  <= '0;
            end else begin
               playing_q <= 1'b1;
               // An in-flight read must finish (and be thrown away) before the new window starts.
               if (!req_q) begin
                  state_q <= FETCH;
                  req_q   <= 1'b1;
                  addr_q  <= wave_start_in;
               end else if (mem_ack_in) begin
                  state_q <= FETCH;
                  req_q   <= 1'b0;
               end else begin
                  state_q <= DRAIN;
               end
            end
         end else begin
            case (state_q)
               IDLE: if (sample_tick_in) sample_q <= '0;
               FETCH: begin
                  underrun_q <= sample_tick_in;
                  if (ack) begin
                     buf_q   <= mem_data_in;
                     idx_q   <= idx_d;
                     req_q   <= 1'b0;
                     state_q <= FULL;
                  end else if (!req_q) begin
                     req_q  <= 1'b1;
                     addr_q <= addr_d;
                  end
               end
               FULL: if (sample_tick_in) begin
                  sample_q <= buf_q;
                  req_q    <= 1'b1;
                  addr_q   <= addr_d;
                  state_q  <= FETCH;
               end
               DRAIN: begin
                  underrun_q <= sample_tick_in;
                  if (ack) begin
                     req_q   <= 1'b0;
                     state_q <= FETCH;
                  end
               end
            endcase
         end
      end
   end
   assign mem_req_out      = req_q;
   assign mem_addr_out     = addr_q;
   assign sample_out       = sample_q;
   assign sample_valid_out = valid_q;
   assign underrun_out     = underrun_q;
   assign playing_out      = playing_q;
endmodule

// File: tb/tb_wave_playback_ctrl.sv
// tb_wave_playback_ctrl: directed per-cycle vectors plus memory-responder sequences
// for wave_playback_ctrl.
module tb_wave_playback_ctrl;
   logic        clk_in = 1'b0, rst_in = 1'b1;
   logic [29:0] st = '0;
   logic [17:0] wd = '0;
   logic        upd = 1'b0, tick = 1'b0, tb_ack = 1'b0, auto = 1'b0;
   logic [15:0] tb_data = '0;
   logic        mem_req_out, mem_ack_in, sample_valid_out, underrun_out, playing_out;
   logic [29:0] mem_addr_out;
   logic [15:0] mem_data_in, sample_out;
   logic        r_ack = 1'b0;
   logic [15:0] r_data = '0;
   int          r_lat = 2, r_cnt = 0;
   int          nvec = 0, nerr = 0;

   wave_playback_ctrl dut (
      .clk_in(clk_in), .rst_in(rst_in), .wave_start_in(st), .wave_width_in(wd),
      .update_trig_in(upd), .sample_tick_in(tick), .mem_req_out(mem_req_out),
      .mem_addr_out(mem_addr_out), .mem_ack_in(mem_ack_in), .mem_data_in(mem_data_in),
      .sample_out(sample_out), .sample_valid_out(sample_valid_out),
      .underrun_out(underrun_out), .playing_out(playing_out)
   );

   always #5 clk_in = ~clk_in;

   function automatic logic [15:0] mdl(input logic [29:0] a);
      return a[15:0] ^ 16'hC3A5;
   endfunction

   assign mem_ack_in  = auto ? r_ack : tb_ack;
   assign mem_data_in = auto ? r_data : tb_data;

   // Memory model: ack r_lat+1 cycles after it first sees a request.
   always @(posedge clk_in) begin
      r_ack <= 1'b0;
      if (auto && mem_req_out && !r_ack) begin
         if (r_cnt == r_lat) begin
            r_ack  <= 1'b1;
            r_data <= mdl(mem_addr_out);
            r_cnt  <= 0;
         end else r_cnt <= r_cnt + 1;
      end else r_cnt <= 0;
   end

   typedef struct {
      logic        upd;
      logic [29:0] st;
      logic [17:0] wd;
      logic        tick, ack;
      logic [15:0] data;
      logic        req;
      logic [29:0] addr;
      logic [15:0] smp;
      logic        vld, und, ply;
   } vec_t;

   function automatic vec_t mk(input int u, input int s, input int w, input int t, input int a,
                               input int d, input int rq, input int ad, input int sm,
                               input int vl, input int un, input int pl);
      vec_t v;
      v.upd = 1'(u); v.st = 30'(s); v.wd = 18'(w); v.tick = 1'(t); v.ack = 1'(a);
      v.data = 16'(d); v.req = 1'(rq); v.addr = 30'(ad); v.smp = 16'(sm);
      v.vld = 1'(vl); v.und = 1'(un); v.ply = 1'(pl);
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_in);
      #1;
   endtask

   task automatic run_seq(input string name, input logic [29:0] s, input logic [17:0] w,
                          input int lat, input int tper, input int ncyc, input bit allow_und,
                          input int exp_req, input int exp_del);
      int nreq = 0, ndel = 0, nund = 0;
      logic req_prev = 1'b0;
      logic [15:0] last = '0;
      auto = 1'b0;
      upd = 1'b1; st = '0; wd = '0;
      cyc();
      r_lat = lat;
      auto = 1'b1;
      for (int c = 0; c < ncyc; c++) begin
         upd  = (c == 0);
         st   = s;
         wd   = w;
         tick = (c > 0) && (c % tper == 0);
         cyc();
         upd  = 1'b0;
         tick = 1'b0;
         if (mem_req_out && !req_prev) begin
            chk($sformatf("%s addr#%0d", name, nreq), 32'(mem_addr_out),
                32'(s + 30'(nreq % int'(w))));
            nreq++;
         end
         if (sample_valid_out) begin
            if (underrun_out) begin
               nund++;
               if (!allow_und) chk($sformatf("%s no-underrun", name), 32'(underrun_out), 0);
               chk($sformatf("%s repeat", name), 32'(sample_out), 32'(last));
            end else begin
               last = mdl(s + 30'(ndel % int'(w)));
               chk($sformatf("%s sample#%0d", name, ndel), 32'(sample_out), 32'(last));
               ndel++;
            end
         end
         req_prev = mem_req_out;
      end
      if (allow_und) begin
         chk($sformatf("%s underruns seen", name), 32'(nund > 0), 1);
         chk($sformatf("%s deliveries", name), 32'(ndel >= exp_del), 1);
      end else begin
         chk($sformatf("%s requests", name), 32'(nreq), 32'(exp_req));
         chk($sformatf("%s deliveries", name), 32'(ndel), 32'(exp_del));
      end
      auto = 1'b0;
   endtask

   initial begin
      vec_t tbl[$];
      int reqhi;
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(1, 'h100, 3, 0, 0, 0,        1, 'h100, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h100, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h1111,       0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'hDEAD,       0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h101, 'h1111, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h101, 'h1111, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 1, 'h2222,       0, 0, 'h1111, 1, 1, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h102, 'h2222, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h3333,       0, 0, 'h2222, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h100, 'h3333, 1, 0, 1));
      tbl.push_back(mk(1, 'h200, 2, 1, 0, 0,        1, 'h100, 'h3333, 1, 0, 1));
      tbl.push_back(mk(1, 'h500, 2, 0, 0, 0,        1, 'h100, 'h3333, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'hBEEF,       0, 0, 'h3333, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h500, 'h3333, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h5000,       0, 0, 'h3333, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h501, 'h5000, 1, 0, 1));
      tbl.push_back(mk(1, 'h3FFFFFFE, 4, 0, 1, 'h5001, 0, 0, 'h5000, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0,            1, 'h3FFFFFFE, 'h5000, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'hA000,       0, 0, 'h5000, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h3FFFFFFF, 'hA000, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'hA001,       0, 0, 'hA000, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h0, 'hA001, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'hA002,       0, 0, 'hA001, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h1, 'hA002, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'hA003,       0, 0, 'hA002, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h3FFFFFFE, 'hA003, 1, 0, 1));
      tbl.push_back(mk(1, 'h700, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            0, 0, 0, 1, 0, 0));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h1234,       0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 'h40, 1, 0, 0, 0,         1, 'h40, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h0404,       0, 0, 0, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h40, 'h0404, 1, 0, 1));
      tbl.push_back(mk(0, 0, 0, 0, 1, 'h0405,       0, 0, 'h0404, 0, 0, 1));
      tbl.push_back(mk(0, 0, 0, 1, 0, 0,            1, 'h40, 'h0405, 1, 0, 1));

      repeat (2) @(posedge clk_in);
      #1 rst_in = 1'b0;
      foreach (tbl[i]) begin
         upd = tbl[i].upd; st = tbl[i].st; wd = tbl[i].wd; tick = tbl[i].tick;
         tb_ack = tbl[i].ack; tb_data = tbl[i].data;
         cyc();
         nvec++;
         if (mem_req_out !== tbl[i].req || ((tbl[i].req || i == 0) && mem_addr_out !== tbl[i].addr) ||
             sample_out !== tbl[i].smp || sample_valid_out !== tbl[i].vld ||
             underrun_out !== tbl[i].und || playing_out !== tbl[i].ply) begin
            nerr++;
            $display("FAIL vec%0d: got req=%b addr=%h smp=%h vld=%b und=%b ply=%b expected req=%b addr=%h smp=%h vld=%b und=%b ply=%b",
                     i, mem_req_out, mem_addr_out, sample_out, sample_valid_out, underrun_out, playing_out,
                     tbl[i].req, tbl[i].addr, tbl[i].smp, tbl[i].vld, tbl[i].und, tbl[i].ply);
         end
      end
      upd = 1'b0; tick = 1'b0; tb_ack = 1'b0; tb_data = '0;

      run_seq("basic", 30'h100, 18'd3, 2, 20, 130, 1'b0, 7, 6);
      run_seq("underrun", 30'h300, 18'd4, 30, 10, 200, 1'b1, 0, 3);

      upd = 1'b1; st = 30'h900; wd = 18'd2;
      cyc();
      upd = 1'b0;
      chk("rst pre req", 32'(mem_req_out), 1);
      #2 rst_in = 1'b1;
      #1 chk("rst async outputs", 32'({mem_req_out, sample_valid_out, underrun_out, playing_out}) |
                                   32'(mem_addr_out) | 32'(sample_out), 0);
      #3 rst_in = 1'b0;
      reqhi = 0;
      for (int c = 0; c < 10; c++) begin
         tick = c[0];
         cyc();
         tick = 1'b0;
         reqhi += int'(mem_req_out);
      end
      chk("rst no req after release", 32'(reqhi), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
